// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// completion cause codes and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

    // Classify an incoming request; an illegal funct3 outranks misalignment.
    function automatic logic [1:0] request_cause(input logic       we,
                                                 input logic [2:0] funct3,
                                                 input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = (funct3 > FUNCT3_SW);
        else
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        misaligned = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
        if (illegal)
            return CAUSE_ILLEGAL;
        else if (misaligned)
            return CAUSE_MISALIGNED;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit: store-side byte enables and
// lane-replicated write data, load-side lane extraction and extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  store_funct3,
    input  logic [1:0]  store_addr_lo,
    input  logic [31:0] store_wdata,
    output logic [3:0]  store_be,
    output logic [31:0] store_data,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_addr_lo,
    input  logic [31:0] load_word,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store formatting: replicate the operand into every lane it may land on.
    always_comb begin
        store_be   = 4'b0000;
        store_data = store_wdata;
        case (store_funct3)
            FUNCT3_SB: begin
                store_be   = 4'b0001 << store_addr_lo;
                store_data = {4{store_wdata[7:0]}};
            end
            FUNCT3_SH: begin
                store_be   = store_addr_lo[1] ? 4'b1100 : 4'b0011;
                store_data = {2{store_wdata[15:0]}};
            end
            FUNCT3_SW: begin
                store_be   = 4'b1111;
                store_data = store_wdata;
            end
            default: begin
                store_be   = 4'b0000;
                store_data = store_wdata;
            end
        endcase
    end

    assign lane_byte = load_word[{load_addr_lo, 3'b000} +: 8];
    assign lane_half = load_addr_lo[1] ? load_word[31:16] : load_word[15:0];

    // Load formatting: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        load_data = 32'd0;
        case (load_funct3)
            FUNCT3_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            FUNCT3_LH:  load_data = {{16{lane_half[15]}}, lane_half};
            FUNCT3_LW:  load_data = load_word;
            FUNCT3_LBU: load_data = {24'd0, lane_byte};
            FUNCT3_LHU: load_data = {16'd0, lane_half};
            default:    load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns a core load/store into a req/ack memory
// transaction, stalls the core until it completes, and returns load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_fault_o,
    output logic [1:0]  lsu_cause_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // A zero timeout still needs a one-bit counter to keep the code legal.
    localparam int unsigned COUNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t             state;
    state_t             next_state;
    logic [COUNT_W-1:0] count;
    logic [2:0]         op_funct3;
    logic [1:0]         op_addr_lo;
    logic [1:0]         req_cause;
    logic               acked;
    logic               expired;
    logic [3:0]         fmt_be;
    logic [31:0]        fmt_wdata;
    logic [31:0]        fmt_rdata;

    assign req_cause = request_cause(lsu_we_i, lsu_funct3_i, lsu_addr_i[1:0]);
    assign acked     = (state == BUSY) && dmem_ack_i;
    // The counter holds completed BUSY cycles, so this cycle is the last one allowed.
    assign expired   = (TIMEOUT_CYCLES != 0) && ((32'(count) + 32'd1) == TIMEOUT_CYCLES);

    assign lsu_stall_o = lsu_req_i && (state != DONE);
    assign lsu_done_o  = (state == DONE);
    assign lsu_fault_o = (state == DONE) && (lsu_cause_o != CAUSE_NONE);

    lsu_align u_align (
        .store_funct3  (lsu_funct3_i),
        .store_addr_lo (lsu_addr_i[1:0]),
        .store_wdata   (lsu_wdata_i),
        .store_be      (fmt_be),
        .store_data    (fmt_wdata),
        .load_funct3   (op_funct3),
        .load_addr_lo  (op_addr_lo),
        .load_word     (dmem_rdata_i),
        .load_data     (fmt_rdata)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; an ack on the expiry cycle completes normally.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (lsu_req_i)
                    next_state = (req_cause == CAUSE_NONE) ? BUSY : DONE;
            end
            BUSY: begin
                if (acked || expired)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory port, timeout counter, cause and load result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            op_funct3    <= 3'd0;
            op_addr_lo   <= 2'd0;
            count        <= '0;
            lsu_cause_o  <= CAUSE_NONE;
            lsu_rdata_o  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (req_cause == CAUSE_NONE) begin
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= lsu_we_i;
                            dmem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            dmem_be_o    <= fmt_be;
                            dmem_wdata_o <= fmt_wdata;
                            op_funct3    <= lsu_funct3_i;
                            op_addr_lo   <= lsu_addr_i[1:0];
                            count        <= '0;
                        end else begin
                            lsu_cause_o <= req_cause;
                            if (!lsu_we_i)
                                lsu_rdata_o <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    count <= count + COUNT_W'(1);
                    if (acked) begin
                        dmem_req_o  <= 1'b0;
                        lsu_cause_o <= CAUSE_NONE;
                        if (!dmem_we_o)
                            lsu_rdata_o <= fmt_rdata;
                    end else if (expired) begin
                        dmem_req_o  <= 1'b0;
                        lsu_cause_o <= CAUSE_TIMEOUT;
                        if (!dmem_we_o)
                            lsu_rdata_o <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
